// File: rtl/chatter_queue.sv
// Queued speech sequencer: phoneme codes are buffered in a small FIFO and played
// back to back through an external phoneme table and sample ROM, one sample per tick.
module chatter_queue #(
    parameter int CODE_W  = 6,
    parameter int ADDR_W  = 16,
    parameter int SAMP_W  = 8,
    parameter int FIFO_D  = 8,
    parameter int PERIOD  = 12500,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] data,
    input  logic              write,
    input  logic              abort,
    output logic              busy,
    output logic              idle,
    output logic [CODE_W-1:0] tbl_code,
    input  logic [ADDR_W-1:0] tbl_start,
    input  logic [ADDR_W-1:0] tbl_end,
    input  logic              tbl_hush,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [SAMP_W-1:0] rom_data,
    output logic [SAMP_W-1:0] sample,
    output logic              sample_stb,
    output logic              hush
);

    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_D);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PERIOD - 1);
    localparam logic [2:0]       LAT_INIT   = 3'(ROM_LAT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;

    logic [CNT_W-1:0]  period_cnt_reg;
    logic              tick;

    logic [CODE_W-1:0] fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic              fifo_empty;
    logic              push, pop;

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W-1:0] end_reg, end_next;
    logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
    logic [2:0]        lat_reg, lat_next;
    logic [CODE_W-1:0] tbl_code_reg, tbl_code_next;
    logic [SAMP_W-1:0] sample_reg, sample_next;
    logic              stb_reg, stb_next;
    logic              hush_reg, hush_next;
    logic              busy_reg, busy_next;
    logic              idle_reg, idle_next;

    assign tick       = (period_cnt_reg == LAST_COUNT);
    assign fifo_empty = (count_reg == '0);
    // A write in the same cycle as abort is discarded along with the queue.
    assign push       = write && !busy_reg && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n || tick) begin
            period_cnt_reg <= '0;
        end else begin
            period_cnt_reg <= period_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        end_next      = end_reg;
        rom_addr_next = rom_addr_reg;
        lat_next      = lat_reg;
        tbl_code_next = tbl_code_reg;
        sample_next   = sample_reg;
        stb_next      = 1'b0;
        hush_next     = hush_reg;
        pop           = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
            hush_next  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    hush_next = 1'b1;
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        tbl_code_next = fifo_mem[rd_ptr_reg];
                        state_next    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ptr_next   = tbl_start;
                    end_next   = tbl_end;
                    hush_next  = tbl_hush;
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick) begin
                        rom_addr_next = ptr_reg;
                        lat_next      = LAT_INIT;
                        state_next    = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    lat_next = lat_reg - 3'd1;
                    if (lat_reg == 3'd1) begin
                        state_next = ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    sample_next = rom_data;
                    stb_next    = 1'b1;
                    // Chaining straight into LOAD keeps consecutive phonemes gapless.
                    if (ptr_reg == end_reg) begin
                        if (!fifo_empty) begin
                            pop           = 1'b1;
                            tbl_code_next = fifo_mem[rd_ptr_reg];
                            state_next    = ST_LOAD;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        ptr_next   = ptr_reg + ADDR_W'(1);
                        state_next = ST_WAIT;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (abort) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + (PTR_W+1)'(1);
                2'b01:   count_next = count_reg - (PTR_W+1)'(1);
                default: count_next = count_reg;
            endcase
        end
        busy_next = (count_next == FULL_COUNT);
        idle_next = (state_next == ST_IDLE) && (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            end_reg      <= '0;
            rom_addr_reg <= '0;
            lat_reg      <= '0;
            tbl_code_reg <= '0;
            sample_reg   <= '0;
            stb_reg      <= 1'b0;
            hush_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            idle_reg     <= 1'b1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            end_reg      <= end_next;
            rom_addr_reg <= rom_addr_next;
            lat_reg      <= lat_next;
            tbl_code_reg <= tbl_code_next;
            sample_reg   <= sample_next;
            stb_reg      <= stb_next;
            hush_reg     <= hush_next;
            busy_reg     <= busy_next;
            idle_reg     <= idle_next;
        end
    end

    assign busy       = busy_reg;
    assign idle       = idle_reg;
    assign tbl_code   = tbl_code_reg;
    assign rom_addr   = rom_addr_reg;
    assign sample     = sample_reg;
    assign sample_stb = stb_reg;
    assign hush       = hush_reg;

endmodule

// File: tb/tb_chatter_queue.sv
// Bench for chatter_queue: a phoneme-level model expands each accepted code into its
// expected sample list, and a per-cycle monitor checks every strobe against it.
module tb_chatter_queue;

    localparam int CODE_W  = 6;
    localparam int ADDR_W  = 16;
    localparam int SAMP_W  = 8;
    localparam int FIFO_D  = 4;
    localparam int PERIOD  = 16;
    localparam int ROM_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CODE_W-1:0] data;
    logic              write;
    logic              abort;
    logic              busy;
    logic              idle;
    logic [CODE_W-1:0] tbl_code;
    logic [ADDR_W-1:0] tbl_start;
    logic [ADDR_W-1:0] tbl_end;
    logic              tbl_hush;
    logic [ADDR_W-1:0] rom_addr;
    logic [SAMP_W-1:0] rom_data = '0;
    logic [SAMP_W-1:0] sample;
    logic              sample_stb;
    logic              hush;

    always #5 clk = ~clk;

    chatter_queue #(
        .CODE_W(CODE_W), .ADDR_W(ADDR_W), .SAMP_W(SAMP_W),
        .FIFO_D(FIFO_D), .PERIOD(PERIOD), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .write(write), .abort(abort),
        .busy(busy), .idle(idle), .tbl_code(tbl_code), .tbl_start(tbl_start),
        .tbl_end(tbl_end), .tbl_hush(tbl_hush), .rom_addr(rom_addr),
        .rom_data(rom_data), .sample(sample), .sample_stb(sample_stb), .hush(hush)
    );

    // External phoneme table and a one-cycle ROM whose data is the low address byte.
    logic [ADDR_W-1:0] tab_start [64];
    logic [ADDR_W-1:0] tab_end   [64];
    logic              tab_hush  [64];
    assign tbl_start = tab_start[tbl_code];
    assign tbl_end   = tab_end[tbl_code];
    assign tbl_hush  = tab_hush[tbl_code];
    always @(posedge clk) rom_data <= rom_addr[7:0];

    typedef struct {
        logic [7:0] samp;
        logic       hsh;
        bit         chained;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] obs_s[$];
    int         obs_c[$];
    exp_t       cur_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         last_stb_cyc = 0;
    logic [7:0] last_sample  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected strobes for one accepted code; the first sample is gapless only when
    // something is already playing or queued ahead of it.
    task automatic model_accept(input int code);
        logic [ADDR_W-1:0] a;
        bit                ch;
        bit                first;
        ch    = (exp_q.size() != 0);
        a     = tab_start[code];
        first = 1'b1;
        for (int guard = 0; guard < 1000; guard++) begin
            exp_q.push_back('{a[7:0], tab_hush[code], first ? ch : 1'b1});
            if (a == tab_end[code]) break;
            a++;
            first = 1'b0;
        end
    endtask

    task automatic send(input int code, input bit accept);
        data  = CODE_W'(code);
        write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        if (accept) model_accept(code);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && idle === 1'b1) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_in_time"}, 32'(n < 2000), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check({name, "_idle_after"}, idle, 1);
        check({name, "_hush_after"}, hush, 1);
    endtask

    task automatic wait_obs(input int n, input string name);
        int k;
        k = 0;
        while (obs_s.size() < n && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_strobe_in_time"}, 32'(k < 500), 1);
    endtask

    // Monitor: every strobe must match the model; between strobes the sample must hold.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                last_sample = sample;
            end else begin
                if (sample_stb) begin
                    obs_s.push_back(sample);
                    obs_c.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_stb: got sample %0d, expected no strobe", sample);
                    end else begin
                        cur_e = exp_q.pop_front();
                        check("stb_sample", sample, cur_e.samp);
                        check("stb_hush", hush, cur_e.hsh);
                        if (cur_e.chained) check("stb_spacing", 32'(cyc - last_stb_cyc), PERIOD);
                    end
                    last_stb_cyc = cyc;
                end else begin
                    check("sample_hold", sample, last_sample);
                end
                last_sample = sample;
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            tab_start[i] = '0;
            tab_end[i]   = '0;
            tab_hush[i]  = 1'b0;
        end
        tab_start[1]  = 16'd10;    tab_end[1]  = 16'd13;
        tab_start[2]  = 16'd20;    tab_end[2]  = 16'd21;
        tab_start[3]  = 16'd30;    tab_end[3]  = 16'd30;
        tab_start[4]  = 16'd40;    tab_end[4]  = 16'd42;
        tab_start[5]  = 16'd50;    tab_end[5]  = 16'd51;
        tab_start[6]  = 16'd60;    tab_end[6]  = 16'd60;
        tab_start[7]  = 16'd0;     tab_end[7]  = 16'd2;    tab_hush[7] = 1'b1;
        tab_start[8]  = 16'd100;   tab_end[8]  = 16'd100;
        tab_start[9]  = 16'd200;   tab_end[9]  = 16'd209;
        tab_start[10] = 16'hFFFE;  tab_end[10] = 16'h0001;

        rst_n = 1'b0;
        write = 1'b0;
        abort = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", sample, 0);
        check("rst_stb", sample_stb, 0);
        check("rst_hush", hush, 1);
        check("rst_busy", busy, 0);
        check("rst_idle", idle, 1);
        check("rst_tbl_code", tbl_code, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single phoneme, four samples one period apart.
        obs_s.delete(); obs_c.delete();
        send(1, 1'b1);
        check("t1_idle_drops", idle, 0);
        wait_done("t1");
        check("t1_count", obs_s.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_sample", obs_s[i], 32'(10 + i));
        for (int i = 1; i < 4; i++) check("t1_period", 32'(obs_c[i] - obs_c[i-1]), 16);

        // Queue fills while a long phoneme plays; fifth burst write is dropped.
        obs_s.delete(); obs_c.delete();
        send(9, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send(2, 1'b1);
        send(3, 1'b1);
        send(4, 1'b1);
        check("t2_busy_after_3", busy, 0);
        send(5, 1'b1);
        check("t2_busy_after_4", busy, 1);
        send(6, 1'b0);
        check("t2_busy_after_5", busy, 1);
        wait_done("t2");
        check("t2_count", obs_s.size(), 18);
        check("t2_first_of_code2", obs_s[10], 20);
        check("t2_gapless", 32'(obs_c[10] - obs_c[9]), 16);
        check("t2_last", obs_s[17], 51);

        // Pause phoneme.
        obs_s.delete(); obs_c.delete();
        send(7, 1'b1);
        wait_obs(2, "t3");
        check("t3_hush_mid", hush, 1);
        wait_done("t3");
        check("t3_count", obs_s.size(), 3);

        // start == end.
        obs_s.delete(); obs_c.delete();
        send(8, 1'b1);
        wait_done("t4");
        check("t4_count", obs_s.size(), 1);
        check("t4_sample", sample, 100);

        // start > end wraps through the top of the address space.
        obs_s.delete(); obs_c.delete();
        send(10, 1'b1);
        wait_done("t7");
        check("t7_count", obs_s.size(), 4);
        check("t7_s0", obs_s[0], 8'hFE);
        check("t7_s1", obs_s[1], 8'hFF);
        check("t7_s2", obs_s[2], 8'h00);
        check("t7_s3", obs_s[3], 8'h01);

        // Abort mid-phoneme with two codes queued.
        obs_s.delete(); obs_c.delete();
        send(9, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send(2, 1'b1);
        send(3, 1'b1);
        wait_obs(2, "t5");
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check("t5_idle", idle, 1);
        check("t5_hush", hush, 1);
        check("t5_busy", busy, 0);
        repeat (3 * PERIOD) @(posedge clk);
        #1;
        check("t5_no_more_stb", obs_s.size(), 2);
        check("t5_sample_kept", sample, 201);
        abort = 1'b1;
        write = 1'b1;
        data  = CODE_W'(1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        write = 1'b0;
        check("t5_abort_write_idle", idle, 1);
        repeat (2 * PERIOD) @(posedge clk);
        #1;
        check("t5_abort_write_still_idle", idle, 1);
        check("t5_abort_write_no_stb", obs_s.size(), 2);

        // Reset while the second sample is being fetched.
        obs_s.delete(); obs_c.delete();
        send(9, 1'b1);
        wait_obs(1, "t6");
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("t6_sample", sample, 0);
        check("t6_stb", sample_stb, 0);
        check("t6_hush", hush, 1);
        check("t6_busy", busy, 0);
        check("t6_idle", idle, 1);
        check("t6_tbl_code", tbl_code, 0);
        check("t6_rom_addr", rom_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * PERIOD) @(posedge clk);
        #1;
        check("t6_no_stale_stb", obs_s.size(), 1);
        check("t6_idle_after", idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
